pulse_stretcher: RTL

Converts single-cycle event pulses back into a clean, fixed-width level, the inverse of the level-to-pulse edge detection used on the debounced-input path. It sits downstream of the edge/debounce logic and drives indicators, enables or handshake levels that need a guaranteed minimum on-time. Retrigger, cancel and an enforced low gap between stretched levels are supported.

---
 rtl/pulse_stretcher.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into a fixed-width level.
// One down-counter is shared between the hold and gap phases. Retrigger,
// cancel and a mandatory low gap after each hold are supported.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for trig; level and busy low
// HOLD  | level high; counter holds the hold cycles still to go
// GAP   | level low, busy high; counter holds the gap cycles still to go
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 0,
  parameter int RETRIGGER   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  input  logic cancel,
  output logic level,
  output logic busy,
  output logic done,
  output logic dropped
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  // Reload values are "cycles minus one" because the reload edge itself
  // already counts as the first cycle of the phase.
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);
  localparam bit            RETRIG_EN = (RETRIGGER != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dropped_q, dropped_d;

  // Next-state, counter and output decode; outputs are computed from the
  // next state so the registered versions line up with the state register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (cancel) begin
            dropped_d = 1'b1;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end

      S_HOLD: begin
        if (cancel) begin
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (trig && RETRIG_EN) begin
          cnt_d = HOLD_LOAD;
        end else begin
          // Without retrigger a trig here is reported and otherwise ignored.
          if (trig) dropped_d = 1'b1;
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (HAS_GAP) begin
              state_d = S_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      S_GAP: begin
        // cancel has nothing to abort here; a trig is never queued.
        if (trig) dropped_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
  end

  // State, counter and registered outputs; reset aborts any hold or gap
  // immediately without producing a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign level   = level_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule
